// File: rtl/mul_seq_ctrl_if.sv
// Start/done handshake bundle between the decode/execute stage and the
// sequential multiply controller.
interface mul_seq_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             signed_i;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] high_o;
   logic [WIDTH-1:0] low_o;

   modport master (
      output start, signed_i, a_i, b_i,
      input  busy, done, high_o, low_o
   );

   modport slave (
      input  start, signed_i, a_i, b_i,
      output busy, done, high_o, low_o
   );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Shift-and-add multiplier controller: WIDTH iterations over the multiplier
// bits (MSB first), with sign-magnitude correction for signed operands.
module mul_seq_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   mul_seq_ctrl_if.slave bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   logic [1:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic               neg;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_shift;
   logic [2*WIDTH-1:0] acc_next;
   logic               busy_r;
   logic               done_r;
   logic [WIDTH-1:0]   high_r;
   logic [WIDTH-1:0]   low_r;

   // The most negative value maps to itself, which is its correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
      logic signed [WIDTH-1:0] n;
      n = -v;
      magnitude = v[WIDTH-1] ? $unsigned(n) : $unsigned(v);
   endfunction

   function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                     input logic             is_neg);
      apply_sign = is_neg ? -p : p;
   endfunction

   always_comb begin
      acc_shift = {acc[2*WIDTH-2:0], 1'b0};
      acc_next  = acc_shift;
      if (mag_b[cnt])
         acc_next = acc_shift + {{WIDTH{1'b0}}, mag_a};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         mag_a  <= '0;
         mag_b  <= '0;
         neg    <= 1'b0;
         acc    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         high_r <= '0;
         low_r  <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  mag_a  <= bus.signed_i ? magnitude(bus.a_i) : bus.a_i;
                  mag_b  <= bus.signed_i ? magnitude(bus.b_i) : bus.b_i;
                  neg    <= bus.signed_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
                  acc    <= '0;
                  cnt    <= CNT_W'(WIDTH - 1);
                  busy_r <= 1'b1;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               acc <= acc_next;
               // Hold the counter at 0 on the last iteration instead of wrapping.
               if (cnt == '0)
                  state <= S_FINISH;
               else
                  cnt <= cnt - CNT_W'(1);
            end
            S_FINISH: begin
               {high_r, low_r} <= apply_sign(acc, neg);
               done_r          <= 1'b1;
               busy_r          <= 1'b0;
               state           <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.high_o = high_r;
   assign bus.low_o  = low_r;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl (WIDTH=32).
module tb_mul_seq_ctrl;
   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   mul_seq_ctrl_if #(.WIDTH(32)) bus ();

   mul_seq_ctrl #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Called at a negedge; returns at the negedge where done is seen (or after timeout).
   task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] h, output logic [31:0] l,
                         output int lat, output int busy_n, output logic hold_ok);
      logic [31:0] h0, l0;
      h0 = bus.high_o;
      l0 = bus.low_o;
      bus.start = 1'b1; bus.a_i = a; bus.b_i = b; bus.signed_i = s;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.a_i = ~a; bus.b_i = ~b; bus.signed_i = ~s;
      lat = -1; busy_n = 0; hold_ok = 1'b1;
      for (int n = 1; n <= 60 && lat < 0; n++) begin
         @(negedge clk);
         if (bus.done) lat = n;
         else begin
            if (bus.busy) busy_n++;
            if (bus.high_o !== h0 || bus.low_o !== l0) hold_ok = 1'b0;
         end
      end
      h = bus.high_o;
      l = bus.low_o;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.signed_i = 1'b0; bus.a_i = '0; bus.b_i = '0;
      #12;
      tests_run++;
      if ({bus.busy, bus.done, bus.high_o, bus.low_o} !== 66'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got busy=%b done=%b high=%h low=%h, expected all 0",
                  bus.busy, bus.done, bus.high_o, bus.low_o);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_unsigned;
      logic [31:0] h, l; int lat, bn; logic ho;
      do_mul(32'd3, 32'd5, 1'b0, h, l, lat, bn, ho);
      tests_run++;
      if (lat !== 34) begin tests_failed++; $display("FAIL unsigned_latency: got %0d, expected 34", lat); end
      tests_run++;
      if (bn !== 33) begin tests_failed++; $display("FAIL unsigned_busy_cycles: got %0d, expected 33", bn); end
      tests_run++;
      if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL busy_at_done: got %b, expected 0", bus.busy); end
      tests_run++;
      if ({h, l} !== 64'h0000_0000_0000_000F) begin
         tests_failed++; $display("FAIL unsigned_3x5: got %h_%h, expected 00000000_0000000f", h, l);
      end
      tests_run++;
      if (ho !== 1'b1) begin tests_failed++; $display("FAIL outputs_hold_in_run: got %b, expected 1", ho); end
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL done_single_pulse: got %b, expected 0", bus.done); end
   endtask

   task automatic test_unsigned_max;
      logic [31:0] h, l; int lat, bn; logic ho;
      do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, h, l, lat, bn, ho);
      tests_run++;
      if ({h, l} !== 64'hFFFF_FFFE_0000_0001) begin
         tests_failed++; $display("FAIL unsigned_max: got %h_%h, expected fffffffe_00000001", h, l);
      end
      @(negedge clk);
   endtask

   task automatic test_signed;
      logic [31:0] h, l; int lat, bn; logic ho;
      do_mul(32'hFFFF_FFFD, 32'd7, 1'b1, h, l, lat, bn, ho);
      tests_run++;
      if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
         tests_failed++; $display("FAIL signed_m3x7: got %h_%h, expected ffffffff_ffffffeb", h, l);
      end
      @(negedge clk);
      do_mul(32'hFFFF_FFFD, 32'd7, 1'b0, h, l, lat, bn, ho);
      tests_run++;
      if ({h, l} !== 64'h0000_0006_FFFF_FFEB) begin
         tests_failed++; $display("FAIL unsigned_fffffffdx7: got %h_%h, expected 00000006_ffffffeb", h, l);
      end
      @(negedge clk);
      do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, h, l, lat, bn, ho);
      tests_run++;
      if ({h, l} !== 64'h4000_0000_0000_0000) begin
         tests_failed++; $display("FAIL signed_min_sq: got %h_%h, expected 40000000_00000000", h, l);
      end
      @(negedge clk);
      do_mul(32'h8000_0000, 32'd1, 1'b1, h, l, lat, bn, ho);
      tests_run++;
      if ({h, l} !== 64'hFFFF_FFFF_8000_0000) begin
         tests_failed++; $display("FAIL signed_min_x1: got %h_%h, expected ffffffff_80000000", h, l);
      end
      @(negedge clk);
      do_mul(32'd0, 32'hFFFF_FFF0, 1'b1, h, l, lat, bn, ho);
      tests_run++;
      if ({h, l} !== 64'd0) begin
         tests_failed++; $display("FAIL signed_zero: got %h_%h, expected 00000000_00000000", h, l);
      end
      @(negedge clk);
   endtask

   task automatic test_start_while_busy;
      logic [31:0] h, l; int lat, dones;
      lat = -1; dones = 0; h = '0; l = '0;
      bus.start = 1'b1; bus.a_i = 32'd2; bus.b_i = 32'd2; bus.signed_i = 1'b0;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int n = 1; n <= 80; n++) begin
         @(negedge clk);
         if (n == 10) begin bus.start = 1'b1; bus.a_i = 32'd9; bus.b_i = 32'd9; end
         else if (n == 11) bus.start = 1'b0;
         if (bus.done) begin
            dones++;
            if (lat < 0) begin lat = n; h = bus.high_o; l = bus.low_o; end
         end
      end
      tests_run++;
      if (dones !== 1) begin tests_failed++; $display("FAIL busy_start_done_count: got %0d, expected 1", dones); end
      tests_run++;
      if (lat !== 34) begin tests_failed++; $display("FAIL busy_start_latency: got %0d, expected 34", lat); end
      tests_run++;
      if ({h, l} !== 64'd4) begin
         tests_failed++; $display("FAIL busy_start_result: got %h_%h, expected 00000000_00000004", h, l);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] h, l; int lat, bn; logic ho;
      do_mul(32'h1234_5678, 32'h10, 1'b0, h, l, lat, bn, ho);
      tests_run++;
      if ({h, l} !== 64'h0000_0001_2345_6780) begin
         tests_failed++; $display("FAIL b2b_first: got %h_%h, expected 00000001_23456780", h, l);
      end
      do_mul(32'd100, 32'd200, 1'b0, h, l, lat, bn, ho);
      tests_run++;
      if (lat !== 34) begin tests_failed++; $display("FAIL b2b_second_latency: got %0d, expected 34", lat); end
      tests_run++;
      if ({h, l} !== 64'd20000) begin
         tests_failed++; $display("FAIL b2b_second: got %h_%h, expected 00000000_00004e20", h, l);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op;
      logic [31:0] h, l; int lat, bn, dones; logic ho;
      bus.start = 1'b1; bus.a_i = 32'd7; bus.b_i = 32'd7; bus.signed_i = 1'b0;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (15) @(negedge clk);
      tests_run++;
      if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL busy_before_reset: got %b, expected 1", bus.busy); end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({bus.busy, bus.done, bus.high_o, bus.low_o} !== 66'd0) begin
         tests_failed++;
         $display("FAIL async_reset_outputs: got busy=%b done=%b high=%h low=%h, expected all 0",
                  bus.busy, bus.done, bus.high_o, bus.low_o);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bus.done || bus.busy) dones++;
      end
      tests_run++;
      if (dones !== 0) begin tests_failed++; $display("FAIL no_done_after_abort: got %0d active cycles, expected 0", dones); end
      do_mul(32'd6, 32'd7, 1'b0, h, l, lat, bn, ho);
      tests_run++;
      if ({h, l} !== 64'h0000_0000_0000_002A) begin
         tests_failed++; $display("FAIL post_reset_6x7: got %h_%h, expected 00000000_0000002a", h, l);
      end
      tests_run++;
      if (lat !== 34) begin tests_failed++; $display("FAIL post_reset_latency: got %0d, expected 34", lat); end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_unsigned();
      test_unsigned_max();
      test_signed();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
